// File: rtl/program_loader.sv
// Byte-serial program loader: assembles FIFO bytes MSB-first into words and writes them to instruction memory.
// Optional macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the halt word.
module program_loader #(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 NB_ADDR   = 8,
    parameter logic [NB_DATA-1:0] HALT_WORD = '1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NB_BYTE-1:0] din,
    input  logic               empty,
    output logic               rd_o,
    input  logic               clear_i,
    output logic               wr_en_o,
    output logic [NB_ADDR-1:0] wr_addr_o,
    output logic [NB_DATA-1:0] wr_data_o,
    output logic               done_o,
    output logic               overflow_o,
    output logic               err_o
);

    localparam int NBYTES = NB_DATA / NB_BYTE;
    localparam int CW     = $clog2(NBYTES + 1);
    localparam logic [NB_ADDR-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        GAP,
        WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] word_q, word_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum_q, csum_d;
    logic [NB_BYTE-1:0] chk_q, chk_d;
    logic               chkPend_q, chkPend_d;
    logic               err_q, err_d;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            word_q    <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
            chk_q     <= '0;
            chkPend_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
            chk_q     <= chk_d;
            chkPend_q <= chkPend_d;
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
        chk_d     = chk_q;
        chkPend_d = chkPend_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    word_d  = (word_q << NB_BYTE) | NB_DATA'(din);
                    cnt_d   = cnt_q + CW'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ din;
`endif
                    state_d = POP;
                end
            end
            POP: state_d = GAP;
            GAP: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                // The checksum byte rides the normal pop handshake; it is judged once popped.
                if (chkPend_q) begin
                    err_d   = (chk_q != csum_q);
                    state_d = DONE;
                end else
`endif
                if (cnt_q == CW'(NBYTES)) state_d = WRITE;
                else                      state_d = IDLE;
            end
            WRITE: begin
                cnt_d = '0;
                if (word_q == HALT_WORD) begin
                    addr_d = (addr_q == ADDR_MAX) ? addr_q : addr_q + NB_ADDR'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else if (addr_q == ADDR_MAX) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + NB_ADDR'(1);
                    state_d = IDLE;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (!empty) begin
                    chk_d     = din;
                    chkPend_d = 1'b1;
                    state_d   = POP;
                end
            end
`endif
            DONE: begin
                if (clear_i) begin
                    addr_d    = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d    = '0;
                    chkPend_d = 1'b0;
                    err_d     = 1'b0;
`endif
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_o       = (state_q == POP);
    assign wr_en_o    = (state_q == WRITE);
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = word_q;
    assign done_o     = (state_q == DONE);
    assign overflow_o = ovf_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign err_o      = err_q;
`else
    assign err_o      = 1'b0;
`endif

endmodule
